// File: rtl/ysyx_22040931_lsu_if.sv
// Bundle of the LSU's three handshakes: MEM-stage request, data-memory port, and WB completion.
// slave is the LSU's view of the bundle; master is the view of everything around it.
interface ysyx_22040931_lsu_if;
  logic        req_valid, req_ready, req_wr, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_wr, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;

  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, req_rd,
           mem_req_ready, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, mem_req_valid, mem_wr, mem_addr, mem_wdata, mem_wmask,
           resp_valid, resp_rdata, resp_rd, resp_err
  );
  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, req_rd,
           mem_req_ready, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, mem_req_valid, mem_wr, mem_addr, mem_wdata, mem_wmask,
           resp_valid, resp_rdata, resp_rd, resp_err
  );
endinterface

// File: rtl/ysyx_22040931_lsu.sv
// Load/store unit: one outstanding access, alignment check, byte-lane steering,
// load extraction/extension, and a bounded wait for load data.
module ysyx_22040931_lsu #(
  parameter int TIMEOUT = 255
) (
  input logic              clock,
  input logic              reset,
  ysyx_22040931_lsu_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d, uns_q, uns_d;
  logic [1:0]    size_q, size_d, err_q, err_d;
  logic [63:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [4:0]    rd_q, rd_d;

  logic          misaligned;
  logic [63:0]   ld_shift, ld_ext;
  logic [7:0]    wmask;

  always_comb begin
    case (bus.req_size)
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      2'b11:   misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Field extraction from the aligned doubleword returned by memory.
  always_comb begin
    ld_shift = bus.mem_rdata >> {addr_q[2:0], 3'b000};
    case (size_q)
      2'b00:   ld_ext = uns_q ? {56'b0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
      2'b01:   ld_ext = uns_q ? {48'b0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'b10:   ld_ext = uns_q ? {32'b0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   wmask = 8'h01 << addr_q[2:0];
      2'b01:   wmask = 8'h03 << addr_q[2:0];
      2'b10:   wmask = 8'h0F << addr_q[2:0];
      default: wmask = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        wr_d    = bus.req_wr;
        uns_d   = bus.req_unsigned;
        size_d  = bus.req_size;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        rd_d    = bus.req_rd;
        rdata_d = 64'b0;
        err_d   = misaligned ? 2'b01 : 2'b00;
        state_d = misaligned ? S_RESP : S_REQ;
      end
      S_REQ: if (bus.mem_req_ready) begin
        state_d = wr_q ? S_RESP : S_WAIT;
        cnt_d   = '0;
      end
      // Data arriving on the last allowed cycle still beats the timeout.
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = ld_ext;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 2'b10;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 64'b0;
      wdata_q <= 64'b0;
      rd_q    <= 5'b0;
      rdata_q <= 64'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_wr        = wr_q;
  assign bus.mem_addr      = {addr_q[63:3], 3'b000};
  assign bus.mem_wdata     = wdata_q << {addr_q[2:0], 3'b000};
  assign bus.mem_wmask     = (state_q == S_REQ && wr_q) ? wmask : 8'h00;
  assign bus.resp_valid    = (state_q == S_RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_rd       = rd_q;
  assign bus.resp_err      = err_q;
endmodule

// File: tb/tb_ysyx_22040931_lsu.sv
// Randomised and directed bench for the LSU; a byte-level reference model predicts every response.
module tb_ysyx_22040931_lsu;
  localparam int T = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_22040931_lsu_if lsu_bus ();
  ysyx_22040931_lsu #(.TIMEOUT(T)) dut (.clock(clock), .reset(reset), .bus(lsu_bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        acc_ready, saw_mreq, unstable, busy_bad, hung, mwr;
    logic [63:0] maddr, mwdata, rdata;
    logic [7:0]  mwmask;
    logic [1:0]  err;
    logic [4:0]  rd;
    logic [31:0] lat;
  } obs_t;

  // Reference: pick n bytes starting at byte a, then extend.
  function automatic logic [63:0] exp_load(logic [63:0] dw, int sz, logic uns, int a);
    int n = 1 << sz;
    logic [63:0] v, m;
    v = dw >> (8 * a);
    m = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    v = v & m;
    if (!uns && n < 8 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  // Drives one operation and plays memory/WB; rv_dly < 0 means load data is never returned.
  task automatic run_op(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                        input logic [63:0] rdata, input int mr_dly, input int rv_dly,
                        input int rr_dly, output obs_t o);
    int cyc = 1, stall = 0, w = 0, hold = 0;
    logic hs = 0, rv_sent = 0, got = 0, done = 0;
    o = '0;
    @(negedge clock);
    lsu_bus.req_valid = 1'b1; lsu_bus.req_wr = wr; lsu_bus.req_size = sz;
    lsu_bus.req_unsigned = uns; lsu_bus.req_addr = addr; lsu_bus.req_wdata = wdata;
    lsu_bus.req_rd = rd;
    o.acc_ready = lsu_bus.req_ready;
    @(negedge clock);
    lsu_bus.req_valid = 1'b0;
    while (!done && cyc < 200) begin
      lsu_bus.mem_rvalid = 1'b0; lsu_bus.mem_req_ready = 1'b0; lsu_bus.resp_ready = 1'b0;
      if (lsu_bus.req_ready) o.busy_bad = 1'b1;
      if (lsu_bus.resp_valid) begin
        if (!got) begin
          got = 1; o.lat = cyc;
          o.rdata = lsu_bus.resp_rdata; o.err = lsu_bus.resp_err; o.rd = lsu_bus.resp_rd;
        end else if (o.rdata !== lsu_bus.resp_rdata || o.err !== lsu_bus.resp_err ||
                     o.rd !== lsu_bus.resp_rd) o.unstable = 1'b1;
        if (hold >= rr_dly) begin lsu_bus.resp_ready = 1'b1; done = 1; end
        else hold++;
      end else if (lsu_bus.mem_req_valid) begin
        if (!o.saw_mreq) begin
          o.saw_mreq = 1'b1; o.maddr = lsu_bus.mem_addr; o.mwdata = lsu_bus.mem_wdata;
          o.mwmask = lsu_bus.mem_wmask; o.mwr = lsu_bus.mem_wr;
        end else if (o.maddr !== lsu_bus.mem_addr || o.mwdata !== lsu_bus.mem_wdata ||
                     o.mwmask !== lsu_bus.mem_wmask || o.mwr !== lsu_bus.mem_wr) o.unstable = 1'b1;
        if (stall >= mr_dly) begin lsu_bus.mem_req_ready = 1'b1; hs = 1; end
        else stall++;
      end else if (hs && !wr && !rv_sent) begin
        if (w == rv_dly) begin
          lsu_bus.mem_rvalid = 1'b1; lsu_bus.mem_rdata = rdata; rv_sent = 1;
        end
        w++;
      end
      @(negedge clock);
      cyc++;
    end
    lsu_bus.resp_ready = 1'b0; lsu_bus.mem_rvalid = 1'b0; lsu_bus.mem_req_ready = 1'b0;
    if (!done) o.hung = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (lsu_bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", lsu_bus.req_ready); end
    n_checks++; if (lsu_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got %b exp 0", lsu_bus.mem_req_valid); end
    n_checks++; if (lsu_bus.mem_wmask !== 8'h00) begin n_fail++; $display("FAIL reset_wmask got %h exp 00", lsu_bus.mem_wmask); end
    n_checks++; if (lsu_bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", lsu_bus.resp_valid); end
    n_checks++; if (lsu_bus.resp_err !== 2'b00) begin n_fail++; $display("FAIL reset_resp_err got %b exp 00", lsu_bus.resp_err); end
    n_checks++; if (lsu_bus.resp_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h exp 0", lsu_bus.resp_rdata); end
    n_checks++; if (lsu_bus.resp_rd !== 5'h0) begin n_fail++; $display("FAIL reset_resp_rd got %h exp 0", lsu_bus.resp_rd); end
  endtask

  task automatic test_lb();
    obs_t o;
    run_op(1'b0, 2'b00, 1'b0, 64'h8000_0003, 64'h0, 5'd7, 64'h0000_0000_8000_0000, 0, 0, 0, o);
    n_checks++; if (o.rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_rdata got %h exp ffffffffffffff80", o.rdata); end
    n_checks++; if (o.err !== 2'b00) begin n_fail++; $display("FAIL lb_err got %b exp 00", o.err); end
    n_checks++; if (o.rd !== 5'd7) begin n_fail++; $display("FAIL lb_rd got %0d exp 7", o.rd); end
    n_checks++; if (o.lat !== 32'd3) begin n_fail++; $display("FAIL lb_latency got %0d exp 3", o.lat); end
    n_checks++; if (o.maddr !== 64'h8000_0000 || o.mwmask !== 8'h00 || o.mwr !== 1'b0) begin n_fail++; $display("FAIL lb_memreq got addr %h mask %h wr %b exp 80000000 00 0", o.maddr, o.mwmask, o.mwr); end
    run_op(1'b0, 2'b00, 1'b1, 64'h8000_0003, 64'h0, 5'd8, 64'h0000_0000_8000_0000, 0, 0, 0, o);
    n_checks++; if (o.rdata !== 64'h80) begin n_fail++; $display("FAIL lbu_rdata got %h exp 80", o.rdata); end
  endtask

  task automatic test_sh();
    obs_t o;
    run_op(1'b1, 2'b01, 1'b0, 64'h8000_0006, 64'h1234, 5'd3, 64'h0, 2, -1, 0, o);
    n_checks++; if (o.maddr !== 64'h8000_0000) begin n_fail++; $display("FAIL sh_addr got %h exp 80000000", o.maddr); end
    n_checks++; if (o.mwmask !== 8'hC0) begin n_fail++; $display("FAIL sh_wmask got %h exp c0", o.mwmask); end
    n_checks++; if (o.mwdata !== 64'h1234_0000_0000_0000) begin n_fail++; $display("FAIL sh_wdata got %h exp 1234000000000000", o.mwdata); end
    n_checks++; if (o.err !== 2'b00 || o.rdata !== 64'h0 || o.mwr !== 1'b1) begin n_fail++; $display("FAIL sh_resp got err %b rdata %h wr %b exp 00 0 1", o.err, o.rdata, o.mwr); end
    n_checks++; if (o.unstable !== 1'b0) begin n_fail++; $display("FAIL sh_stable got %b exp 0", o.unstable); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(1'b0, 2'b10, 1'b0, 64'h8000_0002, 64'h0, 5'd4, 64'hDEAD, 0, 0, 0, o);
    n_checks++; if (o.saw_mreq !== 1'b0) begin n_fail++; $display("FAIL mis_memreq got %b exp 0", o.saw_mreq); end
    n_checks++; if (o.lat !== 32'd1) begin n_fail++; $display("FAIL mis_latency got %0d exp 1", o.lat); end
    n_checks++; if (o.err !== 2'b01 || o.rdata !== 64'h0) begin n_fail++; $display("FAIL mis_resp got err %b rdata %h exp 01 0", o.err, o.rdata); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(1'b0, 2'b11, 1'b0, 64'h8000_0008, 64'h0, 5'd5, 64'h1, 0, -1, 0, o);
    n_checks++; if (o.err !== 2'b10 || o.rdata !== 64'h0) begin n_fail++; $display("FAIL timeout_resp got err %b rdata %h exp 10 0", o.err, o.rdata); end
    n_checks++; if (o.lat !== 32'(2 + T)) begin n_fail++; $display("FAIL timeout_latency got %0d exp %0d", o.lat, 2 + T); end
    run_op(1'b0, 2'b11, 1'b1, 64'h8000_0008, 64'h0, 5'd6, 64'h8765_4321_0FED_CBA9, 0, T - 1, 0, o);
    n_checks++; if (o.err !== 2'b00 || o.rdata !== 64'h8765_4321_0FED_CBA9) begin n_fail++; $display("FAIL lastcycle_resp got err %b rdata %h exp 00 876543210fedcba9", o.err, o.rdata); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_op(1'b0, 2'b10, 1'b1, 64'h8000_0004, 64'h0, 5'd9, 64'hF000_0001_0000_0000, 0, 0, 5, o);
    n_checks++; if (o.rdata !== 64'h0000_0000_F000_0001) begin n_fail++; $display("FAIL lwu_rdata got %h exp f0000001", o.rdata); end
    n_checks++; if (o.unstable !== 1'b0 || o.busy_bad !== 1'b0) begin n_fail++; $display("FAIL lwu_hold got unstable %b req_ready_seen %b exp 0 0", o.unstable, o.busy_bad); end
  endtask

  task automatic test_reset_in_wait();
    obs_t o;
    int seen = 0, rdy_bad = 0;
    @(negedge clock);
    lsu_bus.req_valid = 1'b1; lsu_bus.req_wr = 1'b0; lsu_bus.req_size = 2'b11;
    lsu_bus.req_unsigned = 1'b0; lsu_bus.req_addr = 64'h8000_0010; lsu_bus.req_rd = 5'd11;
    @(negedge clock);
    lsu_bus.req_valid = 1'b0; lsu_bus.mem_req_ready = 1'b1;
    @(negedge clock);
    lsu_bus.mem_req_ready = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; lsu_bus.mem_rvalid = 1'b1; lsu_bus.mem_rdata = 64'h5555;
    @(negedge clock);
    lsu_bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (lsu_bus.resp_valid) seen++;
      if (!lsu_bus.req_ready) rdy_bad++;
      @(negedge clock);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_wait_resp got %0d resp cycles exp 0", seen); end
    n_checks++; if (rdy_bad != 0) begin n_fail++; $display("FAIL rst_wait_idle got %0d busy cycles exp 0", rdy_bad); end
    run_op(1'b0, 2'b01, 1'b0, 64'h8000_0012, 64'h0, 5'd12, 64'h0000_0000_ABCD_0000, 0, 1, 0, o);
    n_checks++; if (o.err !== 2'b00 || o.rdata !== 64'hFFFF_FFFF_FFFF_ABCD || o.rd !== 5'd12) begin n_fail++; $display("FAIL rst_wait_next got err %b rdata %h rd %0d exp 00 ffffffffffffabcd 12", o.err, o.rdata, o.rd); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int k = 0; k < 60; k++) begin
      logic wr = 1'($urandom_range(0, 1)), uns = 1'($urandom_range(0, 1));
      int sz = $urandom_range(0, 3), a, n, mr = $urandom_range(0, 2), rv = $urandom_range(0, 5);
      int rr = $urandom_range(0, 2), lat;
      logic [63:0] addr, wd, dw, er_d;
      logic [1:0] er;
      logic [7:0] em;
      logic mis;
      n = 1 << sz;
      a = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) a = (a / n) * n;
      addr = {32'($urandom), 32'($urandom)};
      addr[2:0] = 3'(a);
      wd = {32'($urandom), 32'($urandom)};
      dw = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock); lsu_bus.mem_rvalid = 1'b1; lsu_bus.mem_rdata = ~dw;
      end
      mis = (a % n) != 0;
      er = mis ? 2'b01 : (!wr && rv >= T) ? 2'b10 : 2'b00;
      er_d = (er != 2'b00 || wr) ? 64'h0 : exp_load(dw, sz, uns, a);
      em = wr ? 8'(((1 << n) - 1) << a) : 8'h00;
      lat = mis ? 1 : wr ? 2 + mr : (rv >= T) ? 2 + mr + T : 3 + mr + rv;
      run_op(wr, 2'(sz), uns, addr, wd, 5'(k), dw, mr, rv, rr, o);
      n_checks++; if (o.err !== er) begin n_fail++; $display("FAIL rnd%0d_err got %b exp %b", k, o.err, er); end
      n_checks++; if (o.rdata !== er_d) begin n_fail++; $display("FAIL rnd%0d_rdata got %h exp %h", k, o.rdata, er_d); end
      n_checks++; if (o.rd !== 5'(k) || o.lat !== 32'(lat)) begin n_fail++; $display("FAIL rnd%0d_rd_lat got %0d/%0d exp %0d/%0d", k, o.rd, o.lat, k, lat); end
      n_checks++; if (o.saw_mreq !== !mis) begin n_fail++; $display("FAIL rnd%0d_memreq got %b exp %b", k, o.saw_mreq, !mis); end
      if (!mis) begin
        n_checks++; if (o.maddr !== {addr[63:3], 3'b000} || o.mwmask !== em || o.mwr !== wr) begin n_fail++; $display("FAIL rnd%0d_bus got %h %h %b exp %h %h %b", k, o.maddr, o.mwmask, o.mwr, {addr[63:3], 3'b000}, em, wr); end
        if (wr) begin
          n_checks++; if (o.mwdata !== (wd << (8 * a))) begin n_fail++; $display("FAIL rnd%0d_wdata got %h exp %h", k, o.mwdata, wd << (8 * a)); end
        end
      end
      n_checks++; if (o.unstable || o.busy_bad || o.hung || !o.acc_ready) begin n_fail++; $display("FAIL rnd%0d_protocol got unst %b busy %b hung %b acc %b exp 0 0 0 1", k, o.unstable, o.busy_bad, o.hung, o.acc_ready); end
    end
  endtask

  initial begin
    lsu_bus.req_valid = 1'b0; lsu_bus.req_wr = 1'b0; lsu_bus.req_size = 2'b00;
    lsu_bus.req_unsigned = 1'b0; lsu_bus.req_addr = 64'h0; lsu_bus.req_wdata = 64'h0;
    lsu_bus.req_rd = 5'h0; lsu_bus.mem_req_ready = 1'b0; lsu_bus.mem_rvalid = 1'b0;
    lsu_bus.mem_rdata = 64'h0; lsu_bus.resp_ready = 1'b0;
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22040931_lsu.md
YSYX_22040931_LSU -- requirements
Module: ysyx_22040931_lsu

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles in WAIT before a load aborts with error.
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 req_valid  in  1  MEM stage presents a memory operation.
REQ-005 req_ready  out  1  LSU accepts the operation this cycle.
REQ-006 req_wr  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  encoding: 00 B, 01 H, 10 W, 11 D (ysyx_22040931_SIZE_* encoding).
REQ-008 req_unsigned  in  1  zero-extend load (LBU/LHU/LWU) when 1; sign-extend when 0.
REQ-009 req_addr  in  64  byte address.
REQ-010 req_wdata  in  64  store data, right-aligned.
REQ-011 req_rd  in  5  destination register tag, returned unchanged.
REQ-012 mem_req_valid  out  1  request to data memory.
REQ-013 mem_req_ready  in  1  memory accepts request.
REQ-014 mem_wr  out  1  store request.
REQ-015 mem_addr  out  64  req_addr with bits [2:0] forced to 0.
REQ-016 mem_wdata  out  64  req_wdata shifted left by 8*req_addr[2:0].
REQ-017 mem_wmask  out  8  byte-lane enables.
REQ-018 mem_rvalid  in  1  load data returned.
REQ-019 mem_rdata  in  64  aligned 8-byte doubleword.
REQ-020 resp_valid  out  1  completion to WB side.
REQ-021 resp_ready  in  1  consumer takes completion.
REQ-022 resp_rdata  out  64  extended load result; 0 for stores and errors.
REQ-023 resp_rd  out  5  latched req_rd.
REQ-024 resp_err  out  2  00 ok, 01 misaligned, 10 timeout.

Function
REQ-025 FSM states IDLE, REQ, WAIT, RESP; one operation outstanding at a time.
REQ-026 req_ready = 1 only in IDLE; on req_valid&req_ready, latch wr/size/unsigned/addr/wdata/rd.
REQ-027 Misaligned check on accept: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0; B never misaligned.
REQ-028 Misaligned: IDLE->RESP next cycle, resp_err=01, no mem_req_valid ever asserted for that op.
REQ-029 Aligned: IDLE->REQ; in REQ mem_req_valid=1 with mem_addr/mem_wdata/mem_wmask/mem_wr held stable until mem_req_ready.
REQ-030 wmask: B 0x01<<a, H 0x03<<a, W 0x0F<<a, D 0xFF, a=addr[2:0]; mem_wmask=0 for loads.
REQ-031 REQ handshake, store: ->RESP, resp_err=00, resp_rdata=0.
REQ-032 REQ handshake, load: ->WAIT; counter cleared to 0.
REQ-033 WAIT: counter increments each cycle without mem_rvalid; on mem_rvalid capture extended data, ->RESP, err=00.
REQ-034 Counter reaching TIMEOUT without mem_rvalid: ->RESP, err=10, rdata=0; mem_rvalid in the same cycle wins (err=00).
REQ-035 Load extraction: field = mem_rdata >> 8*a, truncated to size, then sign/zero-extended to 64; D ignores req_unsigned.
REQ-036 RESP: resp_valid=1, outputs stable until resp_ready; on handshake ->IDLE (no same-cycle new accept; min 3-cycle store throughput).
REQ-037 mem_rvalid outside WAIT is ignored (no state change).
REQ-038 Minimum load latency: accept at cycle N, mem_req_ready at N+1, mem_rvalid at N+2 -> resp_valid at N+3.

Reset
REQ-039 On reset: state IDLE, counter 0, req_ready 1, mem_req_valid 0, mem_wmask 0, resp_valid 0, resp_err 00, resp_rdata 0, resp_rd 0.
REQ-040 Reset in any state aborts the operation without response; a late mem_rvalid is then ignored per REQ-037.

Verification
REQ-041 LB signed addr 0x80000003, mem_rdata 0x0000_0000_8000_0000 -> resp_rdata 0xFFFF_FFFF_FFFF_FF80, err 00; LBU same -> 0x80.
REQ-042 SH addr 0x80000006, wdata 0x1234 -> mem_addr 0x80000000, wmask 0xC0, mem_wdata 0x1234_0000_0000_0000, resp err 00.
REQ-043 LW addr 0x80000002 -> mem_req_valid stays 0, resp_valid next cycle with err 01.
REQ-044 LD, mem_rvalid withheld, TIMEOUT=4 -> resp err 10, rdata 0; repeat with rvalid on final cycle -> err 00.
REQ-045 LWU addr 0x80000004, mem_rdata 0xF000_0001_0000_0000, resp_ready low 5 cycles -> resp 0x0000_0000_F000_0001 held stable, req_ready 0 throughout.
REQ-046 Reset asserted in WAIT, then mem_rvalid -> IDLE, resp_valid never asserted, next request completes normally.
